ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch stage directly downstream of the program counter unit. Turns each PC value into a halfword request on the instruction memory port and tracks in-order responses. Buffers fetched Thumb instructions with their PC in a small queue for the decode stage. Drives `stall_out` back into the PC unit's stall input and discards stale fetches when a branch redirects the PC.

## Interface
- `DEPTH`, default 4: total slots, queued plus in-flight; power of two, ≥2.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `pc_in  in  32`: current PC from the PC unit.
- `flush_in  in  1`: branch taken; the same net drives the PC unit's branch input.
- `stall_out  out  1`: PC freeze request to the PC unit.
- `imem_req_out  out  1`: fetch request valid.
- `imem_addr_out  out  32`: `{pc_in[31:1],1'b0}`.
- `imem_gnt_in  in  1`: request accepted this cycle.
- `imem_rvalid_in  in  1`: response valid; in order, ≥1 cycle after grant.
- `imem_rdata_in  in  16`: instruction halfword.
- `if_valid_out  out  1`: instruction available to decode.
- `if_instr_out  out  16`: instruction.
- `if_pc_out  out  32`: address of `if_instr_out`.
- `id_ready_in  in  1`: decode accepts; a transfer happens when valid and ready are both high.

## Operation
- State:
  - circular queue of DEPTH entries, each holding {pc, instr, data_valid}.
  - wr/rd/fill pointers.
  - `outst` count of in-flight requests.
  - `drop` count of responses to discard.
- Issue:
  - `imem_req_out = !rst & !flush_in & (alloc < DEPTH)`, where `alloc` counts allocated queue entries.
  - On a grant, allocate an entry at wr_ptr with pc = `imem_addr_out` and data_valid = 0, then increment `outst`.
- `stall_out = !rst & !flush_in & !(imem_req_out & imem_gnt_in)`. The PC advances exactly once per granted request.
- `stall_out` is 0 whenever `flush_in` = 1. This lets the PC unit, where stall has priority over branch, load the target.
- Response:
  - If `drop` > 0, discard the data and decrement `drop`.
  - Otherwise write instr at fill_ptr, set data_valid, advance fill_ptr, and decrement `outst`.
- Output: `if_valid_out` = data_valid of the rd_ptr entry. A transfer frees that entry and advances rd_ptr.
- A slot freed by a transfer is usable for issue from the next cycle. There is no combinational path from `id_ready_in` to `imem_req_out`.
- Flush:
  - Clear every queue entry.
  - Set `drop <= drop + outst - (rvalid accepted this cycle)` and `outst <= 0`.
  - A transfer in the flush cycle still counts as completed.
- Issue is blocked only while `alloc` = DEPTH, never by `drop`. New responses after a flush arrive after all dropped ones because responses are in order.
- A response with `outst` = 0 and `drop` = 0 is a protocol error. Ignore it; in simulation, `$error`.
- Counter widths are `$clog2(DEPTH)+1`, and pointers wrap modulo DEPTH.

## Timing
- Reset: `stall_out`, `imem_req_out`, and `if_valid_out` are 0; queue, `outst` and `drop` are cleared. `if_instr_out` and `if_pc_out` read as 0.
- Latency: a response at edge N gives `if_valid_out` = 1 in cycle N+1.
- Sustained one instruction per cycle needs DEPTH ≥ memory latency + 2.
- Reset takes effect at the clock edge and overrides flush, grant and response in that cycle.
- Flush with a grant in the same cycle: the grant is impossible, because req = 0.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the queue has no data_valid entry at rd_ptr and the accepted response targets rd_ptr, present `imem_rdata_in` and the entry's pc on `if_*` in the same cycle, with `if_valid_out` = 1.
  - If `id_ready_in` = 1, free the entry immediately and do not write it.
  - Latency drops to 0 cycles.
- Undefined: the registered path only, with latency 1.

## Structure
- Shared package `cm0_pkg`: `THUMB_W` = 16, `ADDR_W` = 32, `IFQ_DEPTH_DEF` = 4, and the `if_entry_t` struct {pc, instr, data_valid}.
- One sub-module, `ifq_ptr_ctrl`: wr/rd/fill pointers, `alloc`, `outst` and `drop` bookkeeping. The top holds the entry storage and glue logic.

## Test plan
- Reset: hold `rst` 3 cycles with `imem_rvalid_in` = 1. All outputs must be 0 and no entry may be written.
- Streaming: 1-cycle memory, `id_ready_in` = 1, PC from 0x0, DEPTH = 4. `if_pc_out` = 0x0, 0x2, 0x4… on consecutive cycles from cycle 2, and `stall_out` stays 0.
- Backpressure: `id_ready_in` = 0. Exactly 4 grants occur, `stall_out` = 1 from the 5th cycle on, and the PC holds at 0x8.
- Flush with in-flight requests: 2 outstanding, then `flush_in` with target 0x100. `stall_out` = 0 in the flush cycle. Both old responses are dropped, and the next `if_pc_out` is 0x100.
- Grant stall: `imem_gnt_in` = 0 for 3 cycles. `stall_out` = 1 for those cycles, the PC holds, and no entry is allocated.
- Bypass (`IFETCH_BYPASS_EN`): queue empty and response 0x4770 for PC 0x20. `if_valid_out` = 1 in the same cycle, with `if_instr_out` = 0x4770 and `if_pc_out` = 0x20.

Source files
------------

// File: rtl/cm0_pkg.sv
// Shared types and constants for the Cortex-M0-style fetch front end.
package cm0_pkg;

  localparam int THUMB_W       = 16;
  localparam int ADDR_W        = 32;
  localparam int IFQ_DEPTH_DEF = 4;

  // One fetch-queue slot: the halfword's address, the halfword, and whether it has returned
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [THUMB_W-1:0] instr;
    logic               data_valid;
  } if_entry_t;

endpackage

// File: rtl/ifq_ptr_ctrl.sv
// Pointer and counter bookkeeping for ifetch_queue: write/read/fill pointers,
// allocated-slot count, in-flight request count and pending-discard count.
module ifq_ptr_ctrl
  import cm0_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_grant,
  input  logic                       i_rvalid,
  input  logic                       i_xfer,
  output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output logic [$clog2(DEPTH)-1:0]   o_fill_ptr,
  output logic [$clog2(DEPTH):0]     o_alloc,
  output logic                       o_resp_fill,
  output logic                       o_resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_fill_ptr;
  logic [CW-1:0] r_alloc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic          w_resp_drop;
  logic          w_resp_acc;

  // Responses retire pending discards first; in-order return makes this exact
  assign w_resp_drop = i_rvalid & (r_drop != '0);
  assign o_resp_fill = i_rvalid & (r_drop == '0) & (r_outst != '0);
  assign o_resp_err  = i_rvalid & (r_drop == '0) & (r_outst == '0);
  assign w_resp_acc  = w_resp_drop | o_resp_fill;

  assign o_wr_ptr   = r_wr_ptr;
  assign o_rd_ptr   = r_rd_ptr;
  assign o_fill_ptr = r_fill_ptr;
  assign o_alloc    = r_alloc;

  // Pointer/counter update; a flush empties the queue and turns in-flight requests into discards
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill_ptr <= '0;
      r_alloc    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill_ptr <= '0;
      r_alloc    <= '0;
      r_outst    <= '0;
      r_drop     <= r_drop + r_outst - CW'(w_resp_acc);
    end else begin
      if (i_grant)     r_wr_ptr   <= r_wr_ptr + PW'(1);
      if (i_xfer)      r_rd_ptr   <= r_rd_ptr + PW'(1);
      if (o_resp_fill) r_fill_ptr <= r_fill_ptr + PW'(1);
      r_alloc <= r_alloc + CW'(i_grant) - CW'(i_xfer);
      r_outst <= r_outst + CW'(i_grant) - CW'(o_resp_fill);
      if (w_resp_drop) r_drop <= r_drop - CW'(1);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between the PC unit and decode. Issues halfword
// fetches, buffers in-order responses with their PC, and stalls the PC unit
// when no slot is free. Define IFETCH_BYPASS_EN to forward a response that
// lands on the head slot straight to decode in the same cycle.
module ifetch_queue
  import cm0_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush_in,
  output logic               stall_out,
  output logic               imem_req_out,
  output logic [ADDR_W-1:0]  imem_addr_out,
  input  logic               imem_gnt_in,
  input  logic               imem_rvalid_in,
  input  logic [THUMB_W-1:0] imem_rdata_in,
  output logic               if_valid_out,
  output logic [THUMB_W-1:0] if_instr_out,
  output logic [ADDR_W-1:0]  if_pc_out,
  input  logic               id_ready_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_entry_t     r_q [DEPTH];

  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_fill_ptr;
  logic [CW-1:0] w_alloc;
  logic          w_grant;
  logic          w_xfer;
  logic          w_resp_fill;
  logic          w_resp_err;
  logic          w_bypass;
  logic          w_fill_wr;
  if_entry_t     w_head;

  ifq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush_in),
    .i_grant     (w_grant),
    .i_rvalid    (imem_rvalid_in),
    .i_xfer      (w_xfer),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_fill_ptr  (w_fill_ptr),
    .o_alloc     (w_alloc),
    .o_resp_fill (w_resp_fill),
    .o_resp_err  (w_resp_err)
  );

  // Issue depends only on registered occupancy, so a freed slot is reused next cycle
  assign imem_addr_out = pc_in & ~ADDR_W'(1);
  assign imem_req_out  = !rst & !flush_in & (w_alloc < CW'(DEPTH));
  assign w_grant       = imem_req_out & imem_gnt_in;
  // Low during flush so the PC unit (stall beats branch) can load the target
  assign stall_out     = !rst & !flush_in & !w_grant;

  assign w_head = r_q[w_rd_ptr];

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = !rst & !w_head.data_valid & w_resp_fill & (w_fill_ptr == w_rd_ptr);
`else
  assign w_bypass = 1'b0;
`endif

  assign if_valid_out = !rst & (w_head.data_valid | w_bypass);
  assign if_instr_out = w_bypass ? imem_rdata_in : w_head.instr;
  assign if_pc_out    = w_head.pc;
  assign w_xfer       = if_valid_out & id_ready_in;
  // A bypassed halfword that decode takes immediately never needs storing
  assign w_fill_wr    = w_resp_fill & !(w_bypass & id_ready_in);

  // Slot storage: allocate on grant, fill on response, release on transfer
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      if (w_grant) r_q[w_wr_ptr] <= '{pc: imem_addr_out, instr: '0, data_valid: 1'b0};
      if (w_fill_wr) begin
        r_q[w_fill_ptr].instr      <= imem_rdata_in;
        r_q[w_fill_ptr].data_valid <= 1'b1;
      end
      if (w_xfer) r_q[w_rd_ptr].data_valid <= 1'b0;
    end
  end

  // A response with nothing in flight or pending discard is dropped; flag it in simulation
  always_ff @(posedge clk) begin
    assert (rst || !w_resp_err)
      else $error("ifetch_queue: response received with no request pending");
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        stall_out;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [15:0] imem_rdata_in;
  logic        if_valid_out;
  logic [15:0] if_instr_out;
  logic [31:0] if_pc_out;
  logic        id_ready_in;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .flush_in       (flush_in),
    .stall_out      (stall_out),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .if_valid_out   (if_valid_out),
    .if_instr_out   (if_instr_out),
    .if_pc_out      (if_pc_out),
    .id_ready_in    (id_ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int lat    = 1;
  int n_grant = 0;
  int n_xfer  = 0;

  logic        rst_m = 1'b1, flush_m = 1'b0, gnt_m = 1'b0, rdy_m = 1'b0, force_rv = 1'b0;
  logic [31:0] pc_m = '0, flush_tgt = '0, last_xfer_pc = '0;
  logic        s_stall, s_req, s_valid, s_grant, s_xfer;
  logic [15:0] s_instr;
  logic [31:0] s_pc;

  function automatic logic [15:0] instr_of(input logic [31:0] a);
    return a[15:0] ^ 16'h4750;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One cycle: drive at negedge, sample 1ns later, update scoreboard/memory/PC models
  task automatic step();
    mreq_t       m;
    logic [31:0] e;
    @(negedge clk);
    rst         = rst_m;
    flush_in    = flush_m;
    imem_gnt_in = gnt_m;
    id_ready_in = rdy_m;
    pc_in       = pc_m;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
    if (force_rv) begin
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = 16'hBEEF;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = instr_of(m.addr);
    end
    #1;
    s_stall = stall_out;
    s_req   = imem_req_out;
    s_valid = if_valid_out;
    s_instr = if_instr_out;
    s_pc    = if_pc_out;
    s_grant = imem_req_out & imem_gnt_in;
    s_xfer  = if_valid_out & id_ready_in;
    if (s_xfer) begin
      n_xfer++;
      last_xfer_pc = if_pc_out;
      chk("xfer_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("xfer_pc", if_pc_out, e);
        chk("xfer_instr", {16'h0, if_instr_out}, {16'h0, instr_of(e)});
      end
    end
    if (flush_in) sb.delete();
    if (s_grant) begin
      n_grant++;
      chk("imem_addr", imem_addr_out, pc_m & ~32'h1);
      sb.push_back(pc_m & ~32'h1);
      mem_q.push_back('{addr: pc_m & ~32'h1, due: cyc + lat});
    end
    if (!rst && !stall_out) pc_m = flush_in ? flush_tgt : pc_m + 32'd2;
    cyc++;
  endtask

  task automatic do_reset(input int n, input bit check_out);
    rst_m = 1'b1; flush_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      sb.delete();
      mem_q.delete();
      pc_m = '0;
      if (check_out) begin
        chk("rst_stall", {31'h0, s_stall}, 32'd0);
        chk("rst_req",   {31'h0, s_req},   32'd0);
        chk("rst_valid", {31'h0, s_valid}, 32'd0);
        chk("rst_instr", {16'h0, s_instr}, 32'd0);
        chk("rst_pc",    s_pc,             32'd0);
      end
    end
    rst_m = 1'b0;
    force_rv = 1'b0;
  endtask

  int first_cyc, g0, x0;
  logic [31:0] first_pc;

  initial begin
    rst = 1'b1; flush_in = 1'b0; imem_gnt_in = 1'b0; id_ready_in = 1'b0;
    imem_rvalid_in = 1'b0; imem_rdata_in = '0; pc_in = '0;

    // Reset with a response held high, then stream
    force_rv = 1'b1;
    do_reset(3, 1'b1);
    gnt_m = 1'b1; rdy_m = 1'b1; lat = 1;
`ifdef IFETCH_BYPASS_EN
    first_cyc = 1;
`else
    first_cyc = 2;
`endif
    for (int c = 0; c < 12; c++) begin
      step();
      chk("stream_stall", {31'h0, s_stall}, 32'd0);
      if (c < first_cyc) chk("stream_valid_lo", {31'h0, s_valid}, 32'd0);
      else begin
        chk("stream_valid", {31'h0, s_valid}, 32'd1);
        chk("stream_pc", s_pc, 32'(2 * (c - first_cyc)));
      end
    end

    // Backpressure: decode never ready
    do_reset(2, 1'b0);
    gnt_m = 1'b1; rdy_m = 1'b0; lat = 1; g0 = n_grant;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("bp_stall", {31'h0, s_stall}, 32'(c >= 4));
    end
    chk("bp_grants", 32'(n_grant - g0), 32'd4);
    chk("bp_pc_hold", pc_m, 32'h8);
    rdy_m = 1'b1; x0 = n_xfer;
    for (int c = 0; c < 10; c++) step();
    chk("bp_drain_progress", 32'(n_xfer - x0 >= 4), 32'd1);

    // Flush with two requests in flight
    do_reset(2, 1'b0);
    gnt_m = 1'b1; rdy_m = 1'b0; lat = 3;
    step();
    step();
    flush_m = 1'b1; flush_tgt = 32'h100;
    step();
    chk("fl_stall", {31'h0, s_stall}, 32'd0);
    chk("fl_req",   {31'h0, s_req},   32'd0);
    flush_m = 1'b0; rdy_m = 1'b1; x0 = n_xfer; first_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 14; c++) begin
      step();
      if (s_xfer && n_xfer == x0 + 1) first_pc = s_pc;
    end
    chk("fl_first_pc", first_pc, 32'h100);

    // Grant withheld for three cycles
    do_reset(2, 1'b0);
    gnt_m = 1'b0; rdy_m = 1'b1; lat = 1; g0 = n_grant;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gs_stall", {31'h0, s_stall}, 32'd1);
      chk("gs_req",   {31'h0, s_req},   32'd1);
      chk("gs_valid", {31'h0, s_valid}, 32'd0);
    end
    chk("gs_pc_hold", pc_m, 32'h0);
    chk("gs_no_grant", 32'(n_grant - g0), 32'd0);
    gnt_m = 1'b1; x0 = n_xfer; first_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 6; c++) begin
      step();
      if (s_xfer && n_xfer == x0 + 1) first_pc = s_pc;
    end
    chk("gs_first_pc", first_pc, 32'h0);

    // Single response landing on an empty queue at PC 0x20
    do_reset(2, 1'b0);
    pc_m = 32'h20; gnt_m = 1'b1; rdy_m = 1'b1; lat = 1;
    step();
    chk("bp0_valid", {31'h0, s_valid}, 32'd0);
    step();
`ifdef IFETCH_BYPASS_EN
    chk("byp_valid", {31'h0, s_valid}, 32'd1);
    chk("byp_instr", {16'h0, s_instr}, 32'h4770);
    chk("byp_pc",    s_pc,             32'h20);
`else
    chk("reg_valid_lat", {31'h0, s_valid}, 32'd0);
    step();
    chk("reg_valid", {31'h0, s_valid}, 32'd1);
    chk("reg_instr", {16'h0, s_instr}, 32'h4770);
    chk("reg_pc",    s_pc,             32'h20);
`endif
    for (int c = 0; c < 4; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
